// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage issue bus, D-stage hazard query and HI/LO/busy/stall returns of the MDU.
interface mdu_ctrl_if;
    logic        E_start;
    logic [3:0]  E_mdop;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master (output E_start, E_mdop, E_A, E_B, D_is_md, input busy, md_stall, HI, LO);
    modport slave (input E_start, E_mdop, E_A, E_B, D_is_md, output busy, md_stall, HI, LO);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller owning HI/LO with a fixed-latency busy counter.
// Define MDU_MADD_EN to accept madd/maddu (opcodes 7/8) with a 64-bit HI/LO accumulator.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic clk,
    input logic reset,
    mdu_ctrl_if.slave md
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1) < 4 ? 4 : $clog2(MAXC + 1);
    typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, thi_q, thi_d, tlo_q, tlo_d;
    logic op_mul, op_mad, op_div, op_long, sgn, busy;
    logic [63:0] prod, mul_res;
    logic [31:0] abs_a, abs_b, div_b, q_u, r_u, quo, rem;
    assign op_mul = md.E_mdop == 4'd1 || md.E_mdop == 4'd2;
`ifdef MDU_MADD_EN
    assign op_mad = md.E_mdop == 4'd7 || md.E_mdop == 4'd8;
`else
    assign op_mad = 1'b0;
`endif
    assign op_div = md.E_mdop == 4'd3 || md.E_mdop == 4'd4;
    assign op_long = op_mul | op_mad | op_div;
    assign sgn = md.E_mdop == 4'd1 || md.E_mdop == 4'd3 || md.E_mdop == 4'd7;
    // One 64-bit multiplier serves both signednesses via operand extension.
    assign prod = {{32{sgn & md.E_A[31]}}, md.E_A} * {{32{sgn & md.E_B[31]}}, md.E_B};
`ifdef MDU_MADD_EN
    assign mul_res = op_mad ? {hi_q, lo_q} + prod : prod;
`else
    assign mul_res = prod;
`endif
    assign abs_a = sgn & md.E_A[31] ? -md.E_A : md.E_A;
    assign abs_b = sgn & md.E_B[31] ? -md.E_B : md.E_B;
    assign div_b = abs_b == 32'd0 ? 32'd1 : abs_b;
    assign q_u = abs_a / div_b;
    assign r_u = abs_a % div_b;
    // Magnitude divide then re-sign; 0x8000_0000 / -1 wraps to 0x8000_0000 naturally.
    assign quo = sgn & (md.E_A[31] ^ md.E_B[31]) ? -q_u : q_u;
    assign rem = sgn & md.E_A[31] ? -r_u : r_u;
    assign busy = state_q != IDLE;
    assign md.busy = busy;
    assign md.md_stall = md.D_is_md & (busy | (md.E_start & op_long));
    assign md.HI = hi_q;
    assign md.LO = lo_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        hi_d = hi_q;
        lo_d = lo_q;
        thi_d = thi_q;
        tlo_d = tlo_q;
        if (state_q == IDLE) begin
            if (md.E_start && op_long) begin
                state_d = op_div ? DIV : MULT;
                cnt_d = op_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                {thi_d, tlo_d} = op_div ? (md.E_B == 32'd0 ? {md.E_A, 32'hFFFF_FFFF} : {rem, quo}) : mul_res;
            end
            hi_d = md.E_start && md.E_mdop == 4'd5 ? md.E_A : hi_q;
            lo_d = md.E_start && md.E_mdop == 4'd6 ? md.E_A : lo_q;
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                hi_d = thi_q;
                lo_d = tlo_q;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            thi_q <= '0;
            tlo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            thi_q <= thi_d;
            tlo_q <= tlo_d;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench; driver pushes model HI/LO per issue, negedge monitor pops at commit.
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;
    typedef struct {logic [31:0] hi; logic [31:0] lo;} exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    mdu_ctrl_if md();
    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(md));
    always #5 clk = ~clk;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] mhi = '0, mlo = '0;
    bit force_d = 0;
    function automatic bit is_long(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || op == 4'd7 || op == 4'd8;
`else
        return op >= 4'd1 && op <= 4'd4;
`endif
    endfunction
    function automatic int lat(input logic [3:0] op);
        if (!is_long(op)) return 0;
        return (op == 4'd3 || op == 4'd4) ? DC : MC;
    endfunction
    function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
        longint sa, sb;
        int q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: return sa * sb;
            4'd2: return {32'd0, a} * {32'd0, b};
            4'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            4'd4: return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            4'd5: return {a, lo};
            4'd6: return {hi, a};
`ifdef MDU_MADD_EN
            4'd7: return {hi, lo} + sa * sb;
            4'd8: return {hi, lo} + {32'd0, a} * {32'd0, b};
`endif
            default: return {hi, lo};
        endcase
    endfunction
    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction
    task automatic tick();
        md.D_is_md = force_d ? 1'b1 : 1'($urandom);
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [3:0] op, input logic [31:0] a, b);
        logic [63:0] r;
        r = ref_op(op, a, b, mhi, mlo);
        exp_q.push_back('{r[63:32], r[31:0]});
        {mhi, mlo} = r;
        md.E_start = 1'b1;
        md.E_mdop = op;
        md.E_A = a;
        md.E_B = b;
        tick();
        md.E_start = 1'b0;
        md.E_mdop = 4'($urandom);
        md.E_A = $urandom;
        md.E_B = $urandom;
        repeat (lat(op)) tick();
    endtask
    // Per-cycle monitor: independent busy model, md_stall check, and scoreboard pops.
    int rem_c = 0;
    bit pending = 0;
    bit prev_rst = 0;
    always @(negedge clk) begin
        bit mb, exp_stall;
        exp_t e;
        mb = rem_c != 0;
        checks++;
        if (md.busy !== mb) begin
            errors++;
            $display("FAIL busy @%0t: got %b expected %b", $time, md.busy, mb);
        end
        exp_stall = md.D_is_md & (mb | (md.E_start & is_long(md.E_mdop)));
        checks++;
        if (md.md_stall !== exp_stall) begin
            errors++;
            $display("FAIL md_stall @%0t: got %b expected %b", $time, md.md_stall, exp_stall);
        end
        if (!reset && (pending || prev_rst)) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard @%0t: output event with empty queue", $time);
            end else begin
                e = exp_q.pop_front();
                checks += 2;
                if (md.HI !== e.hi) begin
                    errors++;
                    $display("FAIL HI @%0t: got %h expected %h", $time, md.HI, e.hi);
                end
                if (md.LO !== e.lo) begin
                    errors++;
                    $display("FAIL LO @%0t: got %h expected %h", $time, md.LO, e.lo);
                end
            end
        end
        pending = 0;
        if (reset) rem_c = 0;
        else if (rem_c != 0) begin
            if (md.E_start) begin
                errors++;
                $display("FAIL issue_while_busy @%0t: E_start=1 expected 0", $time);
            end
            if (rem_c == 1) pending = 1;
            rem_c--;
        end else if (md.E_start) begin
            if (is_long(md.E_mdop)) rem_c = lat(md.E_mdop);
            else pending = 1;
        end
        prev_rst = reset;
    end
    initial begin
        md.E_start = 1'b0;
        md.E_mdop = '0;
        md.E_A = '0;
        md.E_B = '0;
        md.D_is_md = 1'b0;
        exp_q.push_back('{32'd0, 32'd0});
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        issue(4'd4, 32'd7, 32'd0);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        force_d = 1;
        issue(4'd3, -32'd7, 32'd2);
        force_d = 0;
        issue(4'd5, 32'h1234_5678, 32'd0);
        issue(4'd6, 32'd5, 32'd0);
        tick();
        md.E_start = 1'b1;
        md.E_mdop = 4'd1;
        md.E_A = 32'h1234_5678;
        md.E_B = 32'h9ABC_DEF0;
        tick();
        md.E_start = 1'b0;
        tick();
        reset = 1'b1;
        {mhi, mlo} = '0;
        exp_q.push_back('{32'd0, 32'd0});
        tick();
        reset = 1'b0;
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0);
        issue(4'd8, 32'd1, 32'd1);
        issue(4'd7, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 250; i++) begin
            issue(4'($urandom_range(0, 9)), rnd32(), rnd32());
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (15) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the five-stage pipeline. It accepts one mult/div/move-to operation per issue from the Execute stage, owns the HI/LO architectural registers and runs a fixed-latency busy counter. It also produces the stall request the hazard unit ORs into its F/D enable and E flush logic. The block sits beside the E-stage ALU: operands come from the forwarded E_Forward1 and E_Forward2 values, and HI/LO read data returns to the E stage for mfhi and mflo.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu), must be ≥1
- DIV_CYCLES, 10, busy cycles for div/divu, must be ≥1
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; one clock, one reset domain
- E_start  input  1  E-stage instruction is an MDU operation this cycle (qualified with E_mdop)
- E_mdop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; other codes are treated as none
- E_A  input  32  forwarded rs value
- E_B  input  32  forwarded rt value
- D_is_md  input  1  D-stage instruction is any of mult/div/mfhi/mflo/mthi/mtlo/madd*
- busy  output  1  operation in flight
- md_stall  output  1  D_is_md & (busy | (E_start & E_mdop in {1,2,3,4,7,8}))
- HI  output  32  current HI register
- LO  output  32  current LO register

## Operation
- State machine has three states: IDLE, MULT, DIV. A 4-bit-or-wider down-counter `cnt` holds the remaining busy cycles.
- IDLE + E_start:
  - mult/multu/madd/maddu go to MULT, with cnt ← MULT_CYCLES.
  - div/divu go to DIV, with cnt ← DIV_CYCLES.
  - Operands are captured and the result is computed into the temp registers tHI/tLO at the same edge.
- mult: {tHI,tLO} = $signed(A)*$signed(B), a 64-bit result. multu computes the same product unsigned.
- div (signed): tLO = quotient truncated toward zero; tHI = remainder, which takes the sign of the dividend.
- div special cases:
  - B=0: tLO=32'hFFFF_FFFF, tHI=A. The same rule applies to divu.
  - A=32'h8000_0000 and B=32'hFFFF_FFFF: tLO=32'h8000_0000, tHI=0.
- MULT/DIV states:
  - cnt decrements every cycle.
  - At the edge where cnt==1, {HI,LO} ← {tHI,tLO}, cnt ← 0, and the state returns to IDLE.
- mthi/mtlo in IDLE: HI (or LO) ← E_A at the same edge. No state change, and busy is not asserted.
- E_start while busy is ignored. The hazard unit must prevent it via md_stall; the bench asserts this never happens.
- busy = (state != IDLE). HI and LO are driven directly from their registers, with no bypass of tHI/tLO.
- Reset: state=IDLE, cnt=0, HI=0, LO=0, tHI=0, tLO=0, busy=0, md_stall=0 (assuming D_is_md=0). Reset in mid-operation abandons the operation, and HI/LO return to 0.

## Timing
- Operation issued in cycle t (E_start=1):
  - busy is high in cycles t+1 … t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - New HI/LO are visible from t+N+1, in the same cycle busy falls.
- md_stall is combinational in cycle t itself, so a dependent D-stage mfhi behind an issuing mult stalls with no bubble gap.
- mthi/mtlo issued in cycle t: the new value is visible at t+1. An mfhi in E at t+1 reads it without a stall.
- Back-to-back: a second mult may issue in cycle t+N+1, the first cycle busy is low.
- md_stall never depends on HI/LO values, so there is no combinational loop with the hazard unit.

## Configuration
- MDU_MADD_EN defined:
  - opcodes 7/8 (madd/maddu) are accepted.
  - {tHI,tLO} = {HI,LO} + product (signed or unsigned respectively), with wrap-around mod 2^64.
  - The HI/LO sampled at issue is used.
  - Latency is MULT_CYCLES.
- MDU_MADD_EN undefined:
  - opcodes 7/8 are treated as none: no state change, and they do not contribute to md_stall.
  - The accumulator adder is not synthesized.

## Test plan
- Reset, then mult A=32'hFFFF_FFFE (−2), B=3 at t → busy high t+1..t+5; at t+6 HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA, busy=0.
- divu A=7, B=0 at t → busy high 10 cycles; then LO=32'hFFFF_FFFF, HI=7. Then div A=32'h8000_0000, B=−1 → LO=32'h8000_0000, HI=0.
- div A=−7, B=2 → LO=32'hFFFF_FFFD (−3), HI=32'hFFFF_FFFF (−1). With D_is_md=1 throughout: md_stall high in t..t+10, low at t+11.
- mthi A=32'h1234_5678 at t → HI=32'h1234_5678 at t+1, busy never asserted, LO unchanged. Next, mtlo A=5 at t+1 → LO=5 at t+2.
- mult issued, reset asserted for one cycle at t+2 → t+3 shows busy=0, HI=LO=0; no later commit of the stale product.
- With MDU_MADD_EN: HI=0, LO=32'hFFFF_FFFF, maddu A=1, B=1 → after 5 busy cycles HI=1, LO=0. Without the macro, the same stimulus leaves HI/LO unchanged and busy=0.
